// File: rtl/afifo_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package afifo_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_t;

  // Width of a round-robin pick index; at least one bit.
  function automatic int unsigned rr_pick_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request searching upward from last_owner+1.
module rr_priority_picker
  import afifo_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = rr_pick_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_owner,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_any_req
);

  always_comb begin
    o_winner  = '0;
    o_any_req = 1'b0;
    // Walk from the farthest offset down so the nearest requester is written last and wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = int'(i_last_owner) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (i_req[idx]) begin
        o_winner  = IDX_W'(idx);
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one async_fifo write port among NUM_REQ requesters.
module fifo_write_arbiter
  import afifo_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]         i_req_last,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_fifo_write_en,
  output logic [WIDTH-1:0]           o_fifo_write_data,
  input  logic                       i_fifo_full,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_busy
);

  localparam int unsigned IdxW = rr_pick_w(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] MaxBurstC = CntW'(MAX_BURST);
  localparam logic [IdxW-1:0] LastReqC  = IdxW'(NUM_REQ - 1);

  arb_state_t      r_state;
  logic [IdxW-1:0] r_owner;
  logic [IdxW-1:0] r_last_owner;
  logic [CntW-1:0] r_beat_cnt;

  logic [IdxW-1:0] w_pick;
  logic            w_any_req;
  logic            w_grant;
  logic            w_owner_valid;
  logic            w_owner_last;
  logic            w_xfer;
  logic            w_burst_end;
  logic [CntW-1:0] w_cnt_inc;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_picker (
    .i_req        (i_req_valid),
    .i_last_owner (r_last_owner),
    .o_winner     (w_pick),
    .o_any_req    (w_any_req)
  );

  assign w_grant       = (r_state == StGrant);
  assign w_owner_valid = i_req_valid[r_owner];
  assign w_owner_last  = i_req_last[r_owner];
  assign w_cnt_inc     = r_beat_cnt + CntW'(1);
  assign w_xfer        = w_grant && w_owner_valid && !i_fifo_full;
  // A stall (full) never releases; otherwise end on last beat, full burst, or owner going idle.
  assign w_burst_end   = w_grant && !i_fifo_full &&
                         (!w_owner_valid || w_owner_last || (w_cnt_inc == MaxBurstC));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= StIdle;
      r_owner      <= '0;
      r_last_owner <= LastReqC;
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_state    <= StGrant;
            r_owner    <= w_pick;
            r_beat_cnt <= '0;
          end
        end
        StGrant: begin
          if (w_xfer) r_beat_cnt <= w_cnt_inc;
          if (w_burst_end) begin
            r_state      <= StIdle;
            r_last_owner <= r_owner;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (w_grant && !i_fifo_full) o_req_ready[r_owner] = 1'b1;
  end

  assign o_fifo_write_en   = w_xfer;
  assign o_fifo_write_data = i_req_data[r_owner*WIDTH +: WIDTH];
  assign o_grant_id        = r_owner;
  assign o_busy            = w_grant;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: directed vector table, reset/round-robin sequences, random traffic vs model.
module tb_fifo_write_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 4;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [NUM_REQ-1:0]       valid;
  logic [NUM_REQ-1:0]       last;
  logic [NUM_REQ-1:0]       ready;
  logic                     full;
  logic                     wen;
  logic                     busy;
  logic [WIDTH-1:0]         wdata;
  logic [1:0]               gid;
  logic [WIDTH-1:0]         rq_data [NUM_REQ];
  logic [NUM_REQ*WIDTH-1:0] data_flat;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    data_flat = '0;
    for (int i = 0; i < NUM_REQ; i++) data_flat[i*WIDTH +: WIDTH] = rq_data[i];
  end

  fifo_write_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .i_clk             (clk),
    .i_reset_n         (reset_n),
    .i_req_valid       (valid),
    .i_req_data        (data_flat),
    .i_req_last        (last),
    .o_req_ready       (ready),
    .o_fifo_write_en   (wen),
    .o_fifo_write_data (wdata),
    .i_fifo_full       (full),
    .o_grant_id        (gid),
    .o_busy            (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic [3:0] ready;
    logic       wen;
    logic       busy;
    logic [1:0] gid;
  } vec_t;

  vec_t tbl [27];

  // Random-phase reference model state
  bit          m_busy;
  int          m_owner, m_last, m_cnt;
  int unsigned seq [NUM_REQ];

  initial begin
    // Directed vectors from reset: 3-beat packet, stall on req 2, idle release, blocked last.
    tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
    tbl[3]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
    tbl[4]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
    tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[6]  = '{4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[7]  = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2};
    for (int r = 8; r <= 12; r++) tbl[r] = '{4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2};
    tbl[13] = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2};
    tbl[14] = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2};
    tbl[15] = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2};
    tbl[16] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2};
    tbl[17] = '{4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2};
    tbl[18] = '{4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3};
    tbl[19] = '{4'b0010, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1, 2'd3};
    tbl[20] = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3};
    tbl[21] = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
    tbl[22] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1};
    tbl[23] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1};
    tbl[24] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
    tbl[25] = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
    tbl[26] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};

    valid   = '0;
    last    = '0;
    full    = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) rq_data[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_wen", 64'(wen), 64'd0);
    chk("reset_gid", 64'(gid), 64'd0);
    reset_n = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int r = 0; r < 27; r++) begin
      @(negedge clk);
      valid = tbl[r].valid;
      last  = tbl[r].last;
      full  = tbl[r].full;
      for (int i = 0; i < NUM_REQ; i++) rq_data[i] = 32'hD000_0000 | (i << 8) | r;
      #1;
      chk($sformatf("tbl%0d_ready", r), 64'(ready), 64'(tbl[r].ready));
      chk($sformatf("tbl%0d_wen", r), 64'(wen), 64'(tbl[r].wen));
      chk($sformatf("tbl%0d_busy", r), 64'(busy), 64'(tbl[r].busy));
      chk($sformatf("tbl%0d_gid", r), 64'(gid), 64'(tbl[r].gid));
      if (tbl[r].wen)
        chk($sformatf("tbl%0d_data", r), 64'(wdata), 64'(32'hD000_0000 | (tbl[r].gid << 8) | r));
    end

    // ---------------- reset in the middle of a burst ----------------
    @(negedge clk);
    valid = 4'b0010;
    last  = '0;
    full  = 1'b0;
    @(negedge clk);
    chk("mid_beat1_gid", 64'(gid), 64'd1);
    @(negedge clk);
    chk("mid_beat2_wen", 64'(wen), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_ready", 64'(ready), 64'd0);
    chk("async_wen", 64'(wen), 64'd0);
    chk("async_gid", 64'(gid), 64'd0);

    // ---------------- round robin, all requesters, no last ----------------
    @(negedge clk);
    reset_n = 1'b1;
    valid   = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) rq_data[i] = 32'hBEEF_0000 | i;
    for (int g = 0; g < 5; g++) begin
      int og;
      og = g % NUM_REQ;
      if (g != 0) @(negedge clk);
      #1;
      chk($sformatf("rr%0d_bubble", g), 64'(busy), 64'd0);
      for (int b = 0; b < MAX_BURST; b++) begin
        @(negedge clk);
        #1;
        chk($sformatf("rr%0d_b%0d_gid", g, b), 64'(gid), 64'(og));
        chk($sformatf("rr%0d_b%0d_ready", g, b), 64'(ready), 64'(1 << og));
        chk($sformatf("rr%0d_b%0d_data", g, b), 64'(wdata), 64'(32'hBEEF_0000 | og));
      end
    end

    // ---------------- random traffic vs reference model ----------------
    @(negedge clk);
    reset_n = 1'b0;
    valid   = '0;
    last    = '0;
    full    = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_busy  = 0;
    m_owner = 0;
    m_last  = NUM_REQ - 1;
    m_cnt   = 0;
    for (int i = 0; i < NUM_REQ; i++) seq[i] = 0;
    begin
      int xfer_id;
      xfer_id = -1;
      for (int c = 0; c < 4000; c++) begin
        logic [3:0] exp_ready;
        logic       exp_wen;
        @(negedge clk);
        if (xfer_id >= 0) begin
          seq[xfer_id]++;
          valid[xfer_id] = 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!valid[i] && $urandom_range(1, 0) == 0) begin
            valid[i]   = 1'b1;
            last[i]    = ($urandom_range(3, 0) == 0);
            rq_data[i] = {8'(i), 24'(seq[i])};
          end else if (valid[i] && $urandom_range(15, 0) == 0) begin
            valid[i] = 1'b0;
          end
        end
        full = ($urandom_range(3, 0) == 0);
        #1;
        exp_ready = (m_busy && !full) ? 4'(1 << m_owner) : 4'b0000;
        exp_wen   = m_busy && valid[m_owner] && !full;
        chk("rnd_ready", 64'(ready), 64'(exp_ready));
        chk("rnd_wen", 64'(wen), 64'(exp_wen));
        chk("rnd_busy", 64'(busy), 64'(m_busy));
        chk("rnd_gid", 64'(gid), 64'(m_owner));
        chk("rnd_onehot0", 64'($onehot0(ready)), 64'd1);
        if (exp_wen) chk("rnd_data_order", 64'(wdata), 64'({8'(m_owner), 24'(seq[m_owner])}));
        xfer_id = -1;
        if (!m_busy) begin
          if (valid != 0) begin
            for (int k = NUM_REQ; k >= 1; k--)
              if (valid[(m_last + k) % NUM_REQ]) m_owner = (m_last + k) % NUM_REQ;
            m_busy = 1;
            m_cnt  = 0;
          end
        end else if (!full) begin
          if (valid[m_owner]) begin
            xfer_id = m_owner;
            m_cnt++;
            if (last[m_owner] || m_cnt == MAX_BURST) begin
              m_busy = 0;
              m_last = m_owner;
            end
          end else begin
            m_busy = 0;
            m_last = m_owner;
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
